// File: rtl/ascon_host_driver.sv
// ascon_host_driver: initiator-side driver for the ASCON core handshake.
// On a host go pulse it starts the core and then answers each core data request
// with one 64-bit word from a source memory: AD words first, then PT words, read
// from consecutive addresses starting at 0. Every ciphertext word the core emits
// goes to a destination memory starting at address 0. The final tag is captured.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   go_i                  host command pulse (accepted only when idle and core ready)
//   ad_size_i, pt_size_i  AD / PT word counts, latched on an accepted go
//   busy_o, done_o        run in progress, one-cycle completion pulse
//   err_o                 sticky protocol error, cleared by reset or an accepted go
//   src_*                 source read port (request pulse, data returns >= 1 cycle later)
//   dst_*                 destination write port for ciphertext words
//   core_*                handshake with the ASCON core
//   tag_o, tag_valid_o    captured tag, held until the next accepted go
module ascon_host_driver #(
  parameter int unsigned BLK_AD_AW = 10,
  parameter int unsigned BLK_PT_AW = 10,
  parameter int unsigned MEM_AW    = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 go_i,
  input  logic [BLK_AD_AW-1:0] ad_size_i,
  input  logic [BLK_PT_AW-1:0] pt_size_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 src_req_o,
  output logic [MEM_AW-1:0]    src_addr_o,
  input  logic [63:0]          src_rdata_i,
  input  logic                 src_rvalid_i,
  output logic                 dst_we_o,
  output logic [MEM_AW-1:0]    dst_addr_o,
  output logic [63:0]          dst_wdata_o,
  output logic                 core_start_o,
  output logic [63:0]          core_data_o,
  output logic                 core_data_valid_o,
  input  logic                 core_data_req_i,
  input  logic                 core_ready_i,
  input  logic                 core_done_i,
  input  logic                 core_ct_valid_i,
  input  logic [63:0]          core_ct_i,
  input  logic                 core_tag_valid_i,
  input  logic [127:0]         core_tag_i,
  output logic [127:0]         tag_o,
  output logic                 tag_valid_o
);

  // One extra bit so ad_size + pt_size never overflows.
  localparam int unsigned CntW = ((BLK_AD_AW > BLK_PT_AW) ? BLK_AD_AW : BLK_PT_AW) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StServe,
    StFetch,
    StPresent,
    StDone
  } state_e;

  state_e               state_q;
  logic [BLK_PT_AW-1:0] pt_size_q;
  logic [CntW-1:0]      total_q;
  logic [CntW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      wr_ptr_q;

  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 src_req_q;
  logic [MEM_AW-1:0]    src_addr_q;
  logic                 dst_we_q;
  logic [MEM_AW-1:0]    dst_addr_q;
  logic [63:0]          dst_wdata_q;
  logic                 core_start_q;
  logic [63:0]          data_q;
  logic                 core_data_valid_q;
  logic [127:0]         tag_q;
  logic                 tag_valid_q;

  logic                 active;
  logic                 ct_room;
  logic                 ct_accept;
  logic                 ct_overflow;
  logic [CntW-1:0]      wr_ptr_next;

  assign active      = (state_q != StIdle);
  assign ct_room     = (wr_ptr_q < CntW'(pt_size_q));
  assign ct_accept   = active && core_ct_valid_i && ct_room;
  assign ct_overflow = active && core_ct_valid_i && !ct_room;
  // Write pointer including a ct word accepted this cycle, so the end-of-run
  // count check also sees a word that arrives together with core_done_i.
  assign wr_ptr_next = wr_ptr_q + CntW'(ct_accept);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= StIdle;
      pt_size_q         <= '0;
      total_q           <= '0;
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
      src_req_q         <= 1'b0;
      src_addr_q        <= '0;
      dst_we_q          <= 1'b0;
      dst_addr_q        <= '0;
      dst_wdata_q       <= '0;
      core_start_q      <= 1'b0;
      data_q            <= '0;
      core_data_valid_q <= 1'b0;
      tag_q             <= '0;
      tag_valid_q       <= 1'b0;
    end else begin
      core_start_q      <= 1'b0;
      src_req_q         <= 1'b0;
      core_data_valid_q <= 1'b0;
      done_q            <= 1'b0;
      dst_we_q          <= 1'b0;

      // Ciphertext capture runs alongside the request FSM.
      if (ct_accept) begin
        dst_we_q    <= 1'b1;
        dst_addr_q  <= MEM_AW'(wr_ptr_q);
        dst_wdata_q <= core_ct_i;
        wr_ptr_q    <= wr_ptr_next;
      end
      if (ct_overflow) begin
        err_q <= 1'b1;
      end

      if (active && core_tag_valid_i) begin
        tag_q       <= core_tag_i;
        tag_valid_q <= 1'b1;
        if (tag_valid_q) begin
          err_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (go_i && core_ready_i) begin
            pt_size_q    <= pt_size_i;
            total_q      <= CntW'(ad_size_i) + CntW'(pt_size_i);
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            err_q        <= 1'b0;
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            busy_q       <= 1'b1;
            core_start_q <= 1'b1;
            state_q      <= StStart;
          end
        end
        StStart: begin
          state_q <= StServe;
        end
        StServe: begin
          if (core_done_i) begin
            done_q  <= 1'b1;
            state_q <= StDone;
            if ((rd_ptr_q != total_q) || (wr_ptr_next != CntW'(pt_size_q))) begin
              err_q <= 1'b1;
            end
          end else if (core_data_req_i) begin
            if (rd_ptr_q < total_q) begin
              src_req_q  <= 1'b1;
              src_addr_q <= MEM_AW'(rd_ptr_q);
              state_q    <= StFetch;
            end else begin
              // Core asked for more words than the run holds.
              err_q <= 1'b1;
            end
          end
        end
        StFetch: begin
          if (core_done_i) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (src_rvalid_i) begin
            data_q            <= src_rdata_i;
            core_data_valid_q <= 1'b1;
            state_q           <= StPresent;
          end
        end
        StPresent: begin
          rd_ptr_q <= rd_ptr_q + CntW'(1);
          state_q  <= StServe;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign src_req_o         = src_req_q;
  assign src_addr_o        = src_addr_q;
  assign dst_we_o          = dst_we_q;
  assign dst_addr_o        = dst_addr_q;
  assign dst_wdata_o       = dst_wdata_q;
  assign core_start_o      = core_start_q;
  assign core_data_o       = data_q;
  assign core_data_valid_o = core_data_valid_q;
  assign tag_o             = tag_q;
  assign tag_valid_o       = tag_valid_q;

endmodule

// File: doc/ascon_host_driver.md
Name: ascon_host_driver

Overview:
- Initiator-side counterpart of the ASCON encryption core handshake.
- On a host command it starts the core, then answers each core data request with one 64-bit word read from a source memory (AD blocks first, then PT blocks).
- Writes every ciphertext word the core emits into a destination memory and captures the final tag.
- Sits between the subsystem register/memory fabric and the ASCON core.

Parameters:
BLK_AD_AW, 10, width of AD block count.
BLK_PT_AW, 10, width of PT block count.
MEM_AW, 12, source/destination word address width; must be >= max(BLK_AD_AW, BLK_PT_AW)+1.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
go_i  in  1  host command pulse
ad_size_i  in  BLK_AD_AW  number of AD words
pt_size_i  in  BLK_PT_AW  number of PT words
busy_o  out  1  run in progress
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky protocol error
src_req_o  out  1  source read request (one-cycle pulse)
src_addr_o  out  MEM_AW  source word address
src_rdata_i  in  64  source read data
src_rvalid_i  in  1  source data valid (latency >= 1, variable)
dst_we_o  out  1  destination write strobe
dst_addr_o  out  MEM_AW  destination word address
dst_wdata_o  out  64  destination write data
core_start_o  out  1  start pulse to core
core_data_o  out  64  data word to core
core_data_valid_o  out  1  data valid to core
core_data_req_i  in  1  core requests a word
core_ready_i  in  1  core idle
core_done_i  in  1  core finished
core_ct_valid_i  in  1  ciphertext word valid
core_ct_i  in  64  ciphertext word
core_tag_valid_i  in  1  tag valid
core_tag_i  in  128  tag
tag_o  out  128  captured tag
tag_valid_o  out  1  tag captured (sticky)

Behaviour:
- Reset: all outputs 0 (including err_o, tag_o, tag_valid_o); FSM to IDLE; all pointers 0. Reset mid-run aborts immediately; no further memory accesses.
- Total word count = ad_size + pt_size, computed at max(BLK_AD_AW, BLK_PT_AW)+1 bits, no overflow.
- Source addressing: AD at addresses 0..ad_size-1; PT at ad_size..total-1. Destination ciphertext addresses start at 0.
- FSM states:
  - IDLE: busy_o=0. go_i=1 with core_ready_i=1 latches sizes, clears read/write pointers, err_o, tag_valid_o and tag_o, then moves to START. go_i with core_ready_i=0, or go_i in any other state, is ignored.
  - START: core_start_o=1 for exactly one cycle -> SERVE. busy_o=1 in every state except IDLE.
  - SERVE:
    - core_done_i -> DONE. This takes priority over core_data_req_i in the same cycle.
    - Else core_data_req_i with rd_ptr < total: src_req_o=1 for one cycle with src_addr_o=rd_ptr -> FETCH.
    - Else core_data_req_i with rd_ptr == total: err_o set, stay in SERVE.
  - FETCH: wait for src_rvalid_i; capture src_rdata_i into data register -> PRESENT. core_done_i here: err_o set -> DONE.
  - PRESENT: core_data_valid_o=1 for exactly one cycle; core_data_o = data register, held until the next capture. rd_ptr increments -> SERVE.
  - DONE: done_o=1 for one cycle -> IDLE. If rd_ptr != total or wr_ptr != pt_size at this point, err_o is set in the same cycle.
- Latency:
  - core_data_req_i to src_req_o: 1 cycle.
  - src_rvalid_i to core_data_valid_o: 1 cycle.
  - Minimum request-to-valid: 3 cycles with 1-cycle source latency.
- Ciphertext capture (any state except IDLE):
  - core_ct_valid_i=1 produces, on the next cycle, dst_we_o=1, dst_addr_o=wr_ptr, dst_wdata_o=registered core_ct_i; wr_ptr then increments.
  - Back-to-back ct words give back-to-back writes.
  - ct valid when wr_ptr == pt_size: err_o set and the write is suppressed.
  - ct valid in IDLE: ignored.
- Tag capture: core_tag_valid_i=1 (not IDLE) loads tag_o and sets tag_valid_o the next cycle; both held until the next accepted go_i or reset. A second tag in the same run overwrites tag_o and sets err_o.
- err_o is cleared only by reset or an accepted go_i.
- Zero sizes: ad=0, pt=0 is legal and performs no source reads; any data request is an error.

Test Plan:
- ad=2, pt=3, source latency 1, source words 0x11..0x55: exactly 5 src_req_o pulses with addr 0..4. core_data_o sequence 0x11,0x22,0x33,0x44,0x55. Core ct 0xA0,0xA1,0xA2 written to dst addr 0,1,2. Tag 0xDEAD…BEEF captured. done_o pulses once; err_o=0.
- Source latency randomised 1..7 cycles, ad=5, pt=5: data order is preserved; core_data_valid_o is never asserted without a preceding src_rvalid_i.
- ad=0, pt=0, core issues one data_req: no src_req_o; err_o=1 on the next cycle.
- go_i with core_ready_i=0, then go_i during busy: no core_start_o, state unchanged.
- Reset asserted in FETCH: next cycle all outputs 0, FSM idle; a following go_i starts a clean run from addr 0.
- core_done_i after only 1 of 3 PT ct words: done_o pulses and err_o=1.
